age_res_station: RTL
====================

Name: age_res_station

Overview:
- Next-generation reservation station for the compare/ALU issue path; replaces the in-order head/tail queue.
- Entries are allocated into any free slot.
- Each cycle the oldest entry whose operands are both ready is issued, so a stalled head no longer blocks younger ready work.
- Sits between rename/dispatch and one functional unit; snoops the CDB for wakeup and squashes entries selectively on early branch recovery.

Parameters:
- RES_DEPTH, 8, number of entries (power of 2, >= 2).
- CDB_PORTS, CDB_NUM, number of CDB wakeup channels snooped.
- PREG_W, $clog2(P_REG_NUM), physical register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- write  in  1  dispatch request
- in  in  res_station_t  dispatched entry (valid, ps1_idx/ps1_valid, ps2_idx/ps2_valid, depen)
- full  out  1  no free entry
- count  out  $clog2(RES_DEPTH)+1  occupied entries
- ready  in  1  FU can accept an op this cycle
- out_valid  out  1  issue this cycle
- out  out  res_station_t  issued entry, '0 when out_valid=0
- cdb_valid  in  CDB_PORTS  per-channel broadcast valid
- cdb_pd_array  in  CDB_PORTS x PREG_W  broadcast physical destinations
- early_flush  in  1  early branch recovery
- recover_idx  in  $clog2(EBR_NUM)  EBR slot being recovered
- depen_rob  in  $clog2(ROB_DEPTH)+1  ROB tag of the mispredicted branch

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: all entries invalid, age matrix cleared, count=0, full=0, out_valid=0, out='0. Reset mid-operation discards all contents in one cycle.
- Storage: RES_DEPTH registered entries plus an age matrix, where older[i][j]=1 means entry i is older than entry j.
- Dispatch: accepted iff write && in.valid && !full && !early_flush; otherwise the write is dropped silently.
  - The accepted entry goes into the lowest-index free slot.
  - Age row update: older[j][new]=1 for every valid j; older[new][*]=0.
- Dispatch wakeup bypass: if in.psX_idx matches any cdb_pd_array[k] with cdb_valid[k] in the dispatch cycle, the stored psX_valid=1.
- Wakeup: for each valid entry and each channel k with cdb_valid[k] and a matching index, psX_valid<=1. Ready takes effect the next cycle.
- Candidate: valid && ps1_valid && ps2_valid.
- Select (combinational): the candidate i for which no other candidate j has older[j][i]=1. Exactly one winner when any candidate exists.
- Issue: out_valid = ready && any candidate && !early_flush.
  - out = winner entry when out_valid, else '0.
  - On the clock edge the winner's slot is invalidated and its age row/column is cleared.
- Latency: an entry dispatched at cycle t issues no earlier than t+1. A CDB broadcast at t (no bypass) makes the entry issuable at t+1.
- Early flush: invalidate every entry with depen.valid[recover_idx] && depen.rob_tags[recover_idx]==depen_rob. Survivors keep their slots, ages and operand state. No issue and no dispatch occur in the flush cycle.
- Count: count_next = count + accept - issue - squashed. full = (count==RES_DEPTH), registered.
- Full boundary: full blocks dispatch even when an issue happens the same cycle (no same-cycle slot reuse).
- Simultaneous events:
  - Wakeup and issue of a different entry in the same cycle both take effect.
  - A flush in the same cycle as a wakeup: the squash wins for matched entries.
- Out of scope: ps index 0 has no special handling (rename delivers it already valid); duplicate CDB broadcasts are harmless.

Decomposition:
- res_station_t, CDB_NUM, P_REG_NUM, EBR_NUM and ROB_DEPTH already live in CDB_types; add nothing new there.
- Sub-module age_matrix_sel holds the age matrix, the allocate/deallocate updates and the oldest-ready one-hot select. Parameters: RES_DEPTH. Inputs: alloc one-hot, dealloc mask, request mask. Output: grant one-hot.
- Free-slot priority encode, wakeup and flush compare stay in age_res_station.

Test Plan:
- Reset, then dispatch 3 entries with all operands valid, ready=1 -> issue order slot0, slot1, slot2 over cycles t+1..t+3; count returns 0; out='0 afterwards.
- Dispatch A (ps1_idx=5, not valid), then B (ready) -> B issues first; CDB cdb_pd_array[0]=5 with cdb_valid[0]=1 -> A issues the next cycle.
- Fill 8 entries, none ready -> full=1, count=8; a 9th write with an issue in the same cycle is dropped; after the issue, full=0 next cycle.
- Dispatch C with ps2_idx=12 in the same cycle as CDB broadcasting 12 -> C issues at t+1 without a further broadcast.
- 4 entries, 2 tagged depen.rob_tags[1]=9 with valid[1]=1; early_flush with recover_idx=1, depen_rob=9 -> count 4->2, out_valid=0 that cycle, survivors issue oldest-first afterwards.
- Issue slot 2, re-dispatch into slot 2 a younger op, make both the older slot-5 op and the new op ready -> slot 5 issues first.

Source files
------------

// File: rtl/CDB_types.sv
// Shared rename/CDB types used across the issue path: physical register file
// sizing, branch-dependency tags and the reservation-station entry layout.
package CDB_types;
    localparam int CDB_NUM   = 2;
    localparam int P_REG_NUM = 64;
    localparam int EBR_NUM   = 4;
    localparam int ROB_DEPTH = 16;

    typedef struct packed {
        logic [EBR_NUM-1:0]                        valid;
        logic [EBR_NUM-1:0][$clog2(ROB_DEPTH):0]   rob_tags;
    } depen_t;

    typedef struct packed {
        logic                         valid;
        logic [$clog2(P_REG_NUM)-1:0] ps1_idx;
        logic                         ps1_valid;
        logic [$clog2(P_REG_NUM)-1:0] ps2_idx;
        logic                         ps2_valid;
        depen_t                       depen;
    } res_station_t;
endpackage

// File: rtl/age_res_station_pkg.sv
// Local widths and helpers for the age-ordered reservation station.
package age_res_station_pkg;
    import CDB_types::*;

    localparam int EBR_W     = $clog2(EBR_NUM);
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH) + 1;

    // True when an entry depends on the branch being recovered.
    function automatic logic depen_hit(input depen_t d,
                                       input logic [EBR_W-1:0] ridx,
                                       input logic [ROB_TAG_W-1:0] rob);
        return d.valid[ridx] && (d.rob_tags[ridx] == rob);
    endfunction
endpackage

// File: rtl/age_res_station_if.sv
// Dispatch/issue/CDB/recovery bundle between rename, the station and its FU.
interface age_res_station_if
    import CDB_types::*, age_res_station_pkg::*;
#(
    parameter int RES_DEPTH = 8,
    parameter int CDB_PORTS = CDB_NUM,
    parameter int PREG_W    = $clog2(P_REG_NUM)
) ();
    // Dispatch: in is taken on a clock edge where write && in.valid && !full &&
    // !early_flush; otherwise it is dropped. Issue: out is consumed on the edge
    // where out_valid is high; out_valid already includes ready, so no stall.
    logic                             write;
    res_station_t                     in;
    logic                             full;
    logic [$clog2(RES_DEPTH):0]       count;
    logic                             ready;
    logic                             out_valid;
    res_station_t                     out;
    logic [CDB_PORTS-1:0]             cdb_valid;
    logic [CDB_PORTS-1:0][PREG_W-1:0] cdb_pd_array;
    logic                             early_flush;
    logic [EBR_W-1:0]                 recover_idx;
    logic [ROB_TAG_W-1:0]             depen_rob;

    modport master (
        output write, in, ready, cdb_valid, cdb_pd_array,
               early_flush, recover_idx, depen_rob,
        input  full, count, out_valid, out
    );

    modport slave (
        input  write, in, ready, cdb_valid, cdb_pd_array,
               early_flush, recover_idx, depen_rob,
        output full, count, out_valid, out
    );
endinterface

// File: rtl/age_res_station_age_matrix_sel.sv
// Age matrix with allocate/deallocate updates and oldest-requester select.
// older_q[i][j] = 1 means slot i was allocated before slot j.
module age_matrix_sel #(
    parameter int RES_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RES_DEPTH-1:0] alloc,
    input  logic [RES_DEPTH-1:0] dealloc,
    input  logic [RES_DEPTH-1:0] req,
    output logic [RES_DEPTH-1:0] grant
);
    logic [RES_DEPTH-1:0] older_q [RES_DEPTH];
    logic [RES_DEPTH-1:0] occ_q;
    logic [RES_DEPTH-1:0] blocked;

    always_comb begin
        blocked = '0;
        for (int i = 0; i < RES_DEPTH; i++) begin
            for (int j = 0; j < RES_DEPTH; j++) begin
                if (j != i && req[j] && older_q[j][i]) blocked[i] = 1'b1;
            end
        end
        grant = req & ~blocked;
    end

    // A new slot is younger than everything already resident; leaving slots
    // drop out of both their row and column.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
            for (int i = 0; i < RES_DEPTH; i++) older_q[i] <= '0;
        end else begin
            occ_q <= (occ_q & ~dealloc) | alloc;
            for (int i = 0; i < RES_DEPTH; i++) begin
                for (int j = 0; j < RES_DEPTH; j++) begin
                    if (dealloc[i] || dealloc[j])
                        older_q[i][j] <= 1'b0;
                    else if (alloc[j])
                        older_q[i][j] <= occ_q[i];
                    else if (alloc[i])
                        older_q[i][j] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/age_res_station.sv
// Out-of-order reservation station: any-slot allocate, CDB wakeup with
// dispatch bypass, oldest-ready issue and selective squash on branch recovery.
module age_res_station
    import CDB_types::*, age_res_station_pkg::*;
#(
    parameter int RES_DEPTH = 8,
    parameter int CDB_PORTS = CDB_NUM,
    parameter int PREG_W    = $clog2(P_REG_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    age_res_station_if.slave rs
);
    localparam int CNT_W = $clog2(RES_DEPTH) + 1;

    res_station_t         ent_q [RES_DEPTH];
    res_station_t         new_ent;
    res_station_t         win_ent;
    logic [RES_DEPTH-1:0] valid_vec;
    logic [RES_DEPTH-1:0] cand;
    logic [RES_DEPTH-1:0] lowest_free;
    logic [RES_DEPTH-1:0] alloc_oh;
    logic [RES_DEPTH-1:0] squash;
    logic [RES_DEPTH-1:0] dealloc;
    logic [RES_DEPTH-1:0] grant;
    logic                 accept;
    logic                 issue;
    logic                 full_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_next;

    function automatic logic cdb_hit(input logic [PREG_W-1:0]                 idx,
                                     input logic [CDB_PORTS-1:0]              v,
                                     input logic [CDB_PORTS-1:0][PREG_W-1:0]  pd);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < CDB_PORTS; k++) begin
            if (v[k] && pd[k] == idx) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < RES_DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            cand[i]      = ent_q[i].valid && ent_q[i].ps1_valid && ent_q[i].ps2_valid;
            squash[i]    = rs.early_flush && ent_q[i].valid &&
                           depen_hit(ent_q[i].depen, rs.recover_idx, rs.depen_rob);
        end
    end

    assign accept      = rs.write && rs.in.valid && !full_q && !rs.early_flush;
    assign issue       = rs.ready && (|cand) && !rs.early_flush;
    // Isolate the lowest clear bit of the occupancy vector.
    assign lowest_free = ~valid_vec & (valid_vec + RES_DEPTH'(1));
    assign alloc_oh    = accept ? lowest_free : '0;
    assign dealloc     = (issue ? grant : '0) | squash;
    assign count_next  = count_q + CNT_W'(accept) - CNT_W'(issue) - CNT_W'($countones(squash));

    always_comb begin
        new_ent           = rs.in;
        new_ent.ps1_valid = rs.in.ps1_valid || cdb_hit(rs.in.ps1_idx, rs.cdb_valid, rs.cdb_pd_array);
        new_ent.ps2_valid = rs.in.ps2_valid || cdb_hit(rs.in.ps2_idx, rs.cdb_valid, rs.cdb_pd_array);
    end

    always_comb begin
        win_ent = '0;
        for (int i = 0; i < RES_DEPTH; i++) begin
            if (grant[i]) win_ent = ent_q[i];
        end
    end

    assign rs.out_valid = issue;
    assign rs.out       = issue ? win_ent : '0;
    assign rs.full      = full_q;
    assign rs.count     = count_q;

    age_matrix_sel #(.RES_DEPTH(RES_DEPTH)) u_age (
        .clk     (clk),
        .rst     (rst),
        .alloc   (alloc_oh),
        .dealloc (dealloc),
        .req     (cand),
        .grant   (grant)
    );

    // Squash and issue take priority over wakeup for the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RES_DEPTH; i++) ent_q[i] <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                if (dealloc[i]) begin
                    ent_q[i] <= '0;
                end else if (alloc_oh[i]) begin
                    ent_q[i] <= new_ent;
                end else if (ent_q[i].valid) begin
                    if (cdb_hit(ent_q[i].ps1_idx, rs.cdb_valid, rs.cdb_pd_array))
                        ent_q[i].ps1_valid <= 1'b1;
                    if (cdb_hit(ent_q[i].ps2_idx, rs.cdb_valid, rs.cdb_pd_array))
                        ent_q[i].ps2_valid <= 1'b1;
                end
            end
            count_q <= count_next;
            full_q  <= (count_next == CNT_W'(RES_DEPTH));
        end
    end
endmodule
